// File: rtl/dm_store_responder.sv
// dm_store_responder
//   Far-end data-memory responder for the M-stage load/store path.
//   One request is accepted at a time. It waits WAIT_CYCLES cycles and then
//   commits against an internal word-organised memory. The response is held
//   until the consumer takes it.
//   Optional build macro: DM_WRITE_TRACE_EN prints one trace line for each
//   committed store.
module dm_store_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Request fields captured at acceptance. Bus activity after acceptance is ignored.
  logic        r_we;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_wdata;
  logic [3:0]  r_count;

  // Registered response.
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  // Handshake / sequencing strobes.
  logic w_accept;
  logic w_commit;
  logic w_rsp_done;

  // Access decode.
  logic             w_misaligned;
  logic             w_bad_size;
  logic             w_out_of_range;
  logic             w_err;
  logic             w_store_commit;
  logic [IDX_W-1:0] w_index;

  // Datapath.
  logic [31:0] w_old_word;
  logic [3:0]  w_lane_en;
  logic [31:0] w_lane_data;
  logic [31:0] w_new_word;
  logic [7:0]  w_load_byte;
  logic [15:0] w_load_half;
  logic [31:0] w_load_data;

  // The storage array is loaded with zeros at time 0 only. Reset never clears it.
  logic [31:0] r_mem [DEPTH_WORDS] = '{default: 32'h0};

  // State register.
  // NOTE: Flops use non-blocking assignments. Every register then samples pre-edge values, which avoids simulation races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, req_ready and the per-state handshake strobes.
  // NOTE: Every signal gets a default before the case statement. Without it, a branch that skips a signal would infer a latch.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = reset_n;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_count == 4'd0) begin
          w_commit     = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_done   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Error classification on the latched request.
  always_comb begin
    w_bad_size     = (r_size == 2'd3);
    w_misaligned   = ((r_size == SZ_HALF) && r_addr[0]) ||
                     ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
    w_out_of_range = ({1'b0, r_addr} >= BYTE_LIMIT);
    w_err          = w_bad_size || w_misaligned || w_out_of_range;
    w_store_commit = w_commit && r_we && !w_err;
    w_index        = r_addr[IDX_W+1:2];
  end

  assign w_old_word = r_mem[w_index];

  // Store merge. Byte enables and the replicated write data are built here,
  // and only the selected lanes replace bytes of the existing word.
  always_comb begin
    w_lane_en   = 4'b0000;
    w_lane_data = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_lane_en   = 4'b0001 << r_addr[1:0];
        w_lane_data = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_lane_en   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{r_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_lane_en   = 4'b1111;
        w_lane_data = r_wdata;
      end
      default: w_lane_en = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      w_new_word[8*i +: 8] = w_lane_en[i] ? w_lane_data[8*i +: 8] : w_old_word[8*i +: 8];
    end
  end

  // Load extraction and extension. Word loads are returned as stored.
  always_comb begin
    w_load_byte = w_old_word[{r_addr[1:0], 3'b000} +: 8];
    w_load_half = r_addr[1] ? w_old_word[31:16] : w_old_word[15:0];
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_signed & w_load_byte[7]}}, w_load_byte};
      SZ_HALF: w_load_data = {{16{r_signed & w_load_half[15]}}, w_load_half};
      SZ_WORD: w_load_data = w_old_word;
      default: w_load_data = 32'h0;
    endcase
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_wdata     <= 32'h0;
      r_count     <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_wdata  <= req_wdata;
        r_count  <= WAIT_INIT;
      end else if ((r_state == ST_WAIT) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end

      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (r_we || w_err) ? 32'h0 : w_load_data;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Memory write port. A store that is aborted by reset never reaches this
  // port, because the commit strobe depends on the reset state register.
  // NOTE: Reset does not touch the storage array. A reset loop over every word would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (w_store_commit) begin
      r_mem[w_index] <= w_new_word;
`ifdef DM_WRITE_TRACE_EN
      $display("%0t@: *%08h <= %08h", $time, {r_addr[31:2], 2'b00}, w_new_word);
`else
`endif
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dm_store_responder.sv
// Self-checking bench for dm_store_responder.
// Two instances share clk/reset: instance 0 uses WAIT_CYCLES=3 and instance 1
// uses WAIT_CYCLES=0, both with a small memory. The reference model is a flat
// little-endian byte array per instance.
module tb_dm_store_responder;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned BYTES  = 4 * DEPTH;
  localparam int unsigned WAIT_A = 3;
  localparam int unsigned WAIT_B = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  byte unsigned model_mem [2][BYTES];

  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dm_store_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dm_store_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? WAIT_A : WAIT_B;
  endfunction

  // Reference behaviour: access size in bytes is 1<<size; the access must be
  // naturally aligned and inside the byte range.
  function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (a >= BYTES) return 1'b1;
    return (a % (32'd1 << s)) != 0;
  endfunction

  task automatic model_access(input int d, input logic we, input logic [31:0] a,
                              input logic [1:0] s, input logic sg, input logic [31:0] wd,
                              output logic [31:0] exp_rd, output logic exp_er);
    int n;
    logic [31:0] v;
    exp_rd = 32'h0;
    exp_er = model_err(a, s);
    if (exp_er) return;
    n = 1 << s;
    if (we) begin
      for (int i = 0; i < n; i++) model_mem[d][a + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(model_mem[d][a + i]) << (8 * i));
      if (n < 4 && sg && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      exp_rd = v;
    end
  endtask

  task automatic scramble(input int d);
    req_we[d]     = 1'($urandom);
    req_addr[d]   = $urandom;
    req_size[d]   = 2'($urandom);
    req_signed[d] = 1'($urandom);
    req_wdata[d]  = $urandom;
  endtask

  // One complete transaction. It checks the acceptance, the latency and the
  // response against the model. During RESP it holds rsp_ready low for
  // 'hold' cycles and checks that the response stays stable. It also
  // optionally keeps req_valid high with new junk each cycle.
  task automatic do_req(input int d, input logic we, input logic [31:0] a, input logic [1:0] s,
                        input logic sg, input logic [31:0] wd, input int hold, input bit busy,
                        input string tag, output logic [31:0] rd_o, output logic er_o);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          t_acc;
    int          t_rsp;
    logic        ok;
    rd_o = 32'h0;
    er_o = 1'b0;
    @(negedge clk);
    req_we[d] = we; req_addr[d] = a; req_size[d] = s; req_signed[d] = sg; req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready[d]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_accept"}, 32'(ok), 32'd1);
    if (!ok) begin req_valid[d] = 1'b0; return; end
    t_acc = cyc + 1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    scramble(d);
    model_access(d, we, a, s, sg, wd, exp_rd, exp_er);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin ok = 1'b1; break; end
      scramble(d);
    end
    check({tag, "_rsp"}, 32'(ok), 32'd1);
    if (!ok) return;
    t_rsp = cyc;
    check({tag, "_lat"}, 32'(t_rsp - t_acc), 32'(1 + wait_of(d)));
    check({tag, "_rdata"}, rsp_rdata[d], exp_rd);
    check({tag, "_err"}, 32'(rsp_err[d]), 32'(exp_er));
    rd_o = rsp_rdata[d];
    er_o = rsp_err[d];
    for (int k = 0; k < hold; k++) begin
      if (busy) begin
        scramble(d);
        req_we[d]    = 1'b1;
        req_valid[d] = 1'b1;
      end
      @(negedge clk);
      check({tag, "_hold_rdy"}, 32'(req_ready[d]), 32'd0);
      check({tag, "_hold_vld"}, 32'(rsp_valid[d]), 32'd1);
      check({tag, "_hold_rd"}, rsp_rdata[d], rd_o);
      check({tag, "_hold_err"}, 32'(rsp_err[d]), 32'(er_o));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    @(negedge clk);
    check({tag, "_done_vld"}, 32'(rsp_valid[d]), 32'd0);
    check({tag, "_done_idle"}, 32'(req_ready[d]), 32'd1);
  endtask

  // Back-to-back loads with rsp_ready tied high. Checks the response latency
  // and the spacing between the two acceptances.
  task automatic back_to_back(input int d, input string tag);
    int   n_acc;
    int   t_acc [2];
    int   t_rsp;
    logic got_rsp;
    @(negedge clk);
    req_we[d] = 1'b0; req_addr[d] = 32'h0; req_size[d] = 2'd2; req_signed[d] = 1'b0;
    req_wdata[d] = 32'h0;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    n_acc   = 0;
    got_rsp = 1'b0;
    t_rsp   = 0;
    t_acc   = '{0, 0};
    for (int k = 0; k < 40 && n_acc < 2; k++) begin
      if (rsp_valid[d] && !got_rsp) begin got_rsp = 1'b1; t_rsp = cyc; end
      if (req_ready[d]) begin t_acc[n_acc] = cyc + 1; n_acc++; end
      @(posedge clk); #1;
      if (n_acc == 2) req_valid[d] = 1'b0;
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    check({tag, "_n_acc"}, 32'(n_acc), 32'd2);
    check({tag, "_got_rsp"}, 32'(got_rsp), 32'd1);
    check({tag, "_rsp_lat"}, 32'(t_rsp - t_acc[0]), 32'(1 + wait_of(d)));
    check({tag, "_period"}, 32'(t_acc[1] - t_acc[0]), 32'(wait_of(d) + 3));
    repeat (wait_of(d) + 4) @(negedge clk);
    rsp_ready[d] = 1'b0;
    check({tag, "_drain_vld"}, 32'(rsp_valid[d]), 32'd0);
    check({tag, "_drain_idle"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0; req_size[d] = 2'd0;
      req_signed[d] = 1'b0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(req_ready[0]), 32'd0);
    check("rst_ready_b", 32'(req_ready[1]), 32'd0);
    check("rst_vld", 32'(rsp_valid[0]), 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'h0);
    check("rst_err", 32'(rsp_err[0]), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready[0]), 32'd1);

    // 1: reset in the middle of WAIT aborts the store.
    req_we[0] = 1'b1; req_addr[0] = 32'h10; req_size[0] = 2'd2; req_wdata[0] = 32'hDEADBEEF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t1_rst_vld", 32'(rsp_valid[0]), 32'd0);
    check("t1_rst_ready", 32'(req_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 1'b0, "t1_lw", rd, er);
    check("t1_lw_lit", rd, 32'h0);

    // 2: byte store merged into a word, then byte loads with both extensions.
    do_req(0, 1'b1, 32'h0, 2'd2, 1'b0, 32'h11223344, 0, 1'b0, "t2_sw", rd, er);
    do_req(0, 1'b1, 32'h2, 2'd0, 1'b0, 32'h000000AB, 1, 1'b0, "t2_sb", rd, er);
    do_req(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, 1'b0, "t2_lw", rd, er);
    check("t2_lw_lit", rd, 32'h11AB3344);
    do_req(0, 1'b0, 32'h2, 2'd0, 1'b1, 32'h0, 0, 1'b0, "t2_lbs", rd, er);
    check("t2_lbs_lit", rd, 32'hFFFFFFAB);
    do_req(0, 1'b0, 32'h2, 2'd0, 1'b0, 32'h0, 0, 1'b0, "t2_lbu", rd, er);
    check("t2_lbu_lit", rd, 32'h000000AB);

    // 3: half store in the upper lanes.
    do_req(0, 1'b1, 32'h6, 2'd1, 1'b0, 32'h00008001, 0, 1'b0, "t3_sh", rd, er);
    do_req(0, 1'b0, 32'h6, 2'd1, 1'b1, 32'h0, 0, 1'b0, "t3_lhs", rd, er);
    check("t3_lhs_lit", rd, 32'hFFFF8001);
    do_req(0, 1'b0, 32'h6, 2'd1, 1'b0, 32'h0, 0, 1'b0, "t3_lhu", rd, er);
    check("t3_lhu_lit", rd, 32'h00008001);
    do_req(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 0, 1'b0, "t3_lw", rd, er);
    check("t3_lw_lit", rd, 32'h80010000);

    // 4: error cases.
    do_req(0, 1'b1, 32'h5, 2'd1, 1'b0, 32'h0000FFFF, 0, 1'b0, "t4_sh_mis", rd, er);
    check("t4_sh_mis_lit", 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h2, 2'd2, 1'b0, 32'h0, 0, 1'b0, "t4_lw_mis", rd, er);
    check("t4_lw_mis_lit", {rd[31:1], er}, 32'h1);
    do_req(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 0, 1'b0, "t4_lw4", rd, er);
    check("t4_lw4_lit", rd, 32'h80010000);
    do_req(0, 1'b0, BYTES, 2'd0, 1'b0, 32'h0, 0, 1'b0, "t4_oor", rd, er);
    check("t4_oor_lit", 32'(er), 32'd1);
    do_req(0, 1'b1, BYTES - 4, 2'd3, 1'b0, 32'h12345678, 0, 1'b0, "t4_sz3", rd, er);
    check("t4_sz3_lit", 32'(er), 32'd1);

    // 5: throughput with rsp_ready tied high.
    back_to_back(0, "t5_w3");
    back_to_back(1, "t5_w0");

    // 6: response back-pressure while the request side stays busy.
    do_req(0, 1'b0, 32'h6, 2'd1, 1'b1, 32'h0, 5, 1'b1, "t6_bp", rd, er);
    check("t6_bp_lit", rd, 32'hFFFF8001);
    do_req(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 0, 1'b0, "t6_lw4", rd, er);

    // Randomised traffic against the byte-array model.
    for (int n = 0; n < 80; n++) begin
      int          d;
      logic [1:0]  s;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = $urandom_range(0, BYTES + 7);
      if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~((32'd1 << s) - 32'd1);
      do_req(d, 1'($urandom), a, s, 1'($urandom), $urandom,
             int'($urandom_range(0, 2)), 1'b0, "rnd", rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
